// File: rtl/conv_enc_packer.sv
// conv_enc_packer: rate-1/2 K=3 convolutional encoder that packs each info byte's
// eight coded pairs into one 16-bit word and closes every frame with a flush word.
module conv_enc_packer #(
  parameter int         FRAME_BYTES = 4,
  parameter logic [2:0] G0          = 3'b111,
  parameter logic [2:0] G1          = 3'b101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  data_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] enc_out,
  output logic        out_valid,
  output logic        flush_word,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ENC, EMIT, FLUSH, EMITF} state_t;
  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        s1_q, s1_d, s2_q, s2_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] shreg_q, shreg_d, enc_out_q, enc_out_d;
  logic        out_valid_q, out_valid_d, flush_word_q, flush_word_d;
  logic        u, c1, c0;
  logic [15:0] shifted;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      bit_cnt_q    <= '0;
      byte_cnt_q   <= '0;
      shreg_q      <= '0;
      enc_out_q    <= '0;
      out_valid_q  <= 1'b0;
      flush_word_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      shreg_q      <= shreg_d;
      enc_out_q    <= enc_out_d;
      out_valid_q  <= out_valid_d;
      flush_word_q <= flush_word_d;
    end
  end
  // Flush cycles feed zeros so the trellis returns to state 0 by the end of the word.
  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    shreg_d      = shreg_q;
    enc_out_d    = enc_out_q;
    u            = (state_q == ENC) ? data_q[7] : 1'b0;
    c1           = ^(G0 & {u, s1_q, s2_q});
    c0           = ^(G1 & {u, s1_q, s2_q});
    shifted      = {shreg_q[13:0], c1, c0};
    out_valid_d  = (state_q == EMIT) || (state_q == EMITF);
    flush_word_d = (state_q == EMITF);
    case (state_q)
      IDLE: if (in_valid) begin
        data_d    = data_in;
        bit_cnt_d = '0;
        state_d   = ENC;
      end
      ENC, FLUSH: begin
        shreg_d   = shifted;
        s1_d      = u;
        s2_d      = s1_q;
        data_d    = {data_q[6:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          enc_out_d  = shifted;
          byte_cnt_d = (state_q == ENC) ? byte_cnt_q + 8'd1 : 8'd0;
          state_d    = (state_q == ENC) ? EMIT : EMITF;
        end
      end
      EMIT: begin
        bit_cnt_d = '0;
        state_d   = (byte_cnt_q == 8'(FRAME_BYTES)) ? FLUSH : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign in_ready   = (state_q == IDLE) && rst;
  assign busy       = (state_q != IDLE);
  assign enc_out    = enc_out_q;
  assign out_valid  = out_valid_q;
  assign flush_word = flush_word_q;
endmodule

// File: tb/tb_conv_enc_packer.sv
// tb_conv_enc_packer: directed checks of the packing encoder with 4-byte and 1-byte frames.
module tb_conv_enc_packer;
  logic        clk = 1'b0, rst = 1'b0;
  logic [7:0]  data_in = '0;
  logic        vld4 = 1'b0, vld1 = 1'b0;
  logic        rdy4, ov4, fw4, bz4, rdy1, ov1, fw1, bz1;
  logic [15:0] eo4, eo1;
  logic [1:0]  mst;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  conv_enc_packer #(.FRAME_BYTES(4)) u4 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(vld4), .in_ready(rdy4),
    .enc_out(eo4), .out_valid(ov4), .flush_word(fw4), .busy(bz4));
  conv_enc_packer #(.FRAME_BYTES(1)) u1 (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(vld1), .in_ready(rdy1),
    .enc_out(eo1), .out_valid(ov1), .flush_word(fw1), .busy(bz1));
  // Reference (7,5) encoder; mst = {s1,s2} carried between calls.
  function automatic logic [15:0] model(input logic [7:0] b);
    logic [15:0] w = '0;
    logic        x;
    for (int i = 7; i >= 0; i--) begin
      x   = b[i];
      w   = {w[13:0], x ^ mst[1] ^ mst[0], x ^ mst[0]};
      mst = {x, mst[1]};
    end
    return w;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    mst = 2'b00;
  endtask
  task automatic send(input bit d, input logic [7:0] b);
    int n = 0;
    while (!(d ? rdy1 : rdy4) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 40) begin
      failures++;
      $display("FAIL send_ready: in_ready stayed 0, required 1");
    end
    data_in = b;
    if (d) vld1 = 1'b1; else vld4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld1 = 1'b0;
    vld4 = 1'b0;
  endtask
  task automatic get(input bit d, output logic [15:0] w, output logic f, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(d ? ov1 : ov4) && lat < 40);
    w = d ? eo1 : eo4;
    f = d ? fw1 : fw4;
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({rdy4, ov4, fw4, bz4, eo4} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs: got rdy=%b ov=%b fw=%b busy=%b enc=%h, required all 0", rdy4, ov4, fw4, bz4, eo4);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({rdy4, rdy1, bz4, bz1} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_release: got rdy4=%b rdy1=%b busy4=%b busy1=%b, required 1 1 0 0", rdy4, rdy1, bz4, bz1);
    end
  endtask
  task automatic test_single();
    logic [15:0] w;
    logic f;
    int lat;
    send(0, 8'h80);
    checks++;
    if (!bz4 || rdy4) begin
      failures++;
      $display("FAIL single_busy: got busy=%b in_ready=%b, required 1 0", bz4, rdy4);
    end
    get(0, w, f, lat);
    checks++;
    if (w !== 16'hEC00 || f !== 1'b0 || lat != 9) begin
      failures++;
      $display("FAIL single_0x80: got enc=%h flush=%b lat=%0d, required EC00 0 9", w, f, lat);
    end
    @(negedge clk);
    checks++;
    if (ov4 !== 1'b0 || eo4 !== 16'hEC00) begin
      failures++;
      $display("FAIL single_pulse: got ov=%b enc=%h, required 0 EC00", ov4, eo4);
    end
  endtask
  task automatic test_frame1();
    logic [15:0] w;
    logic f;
    int lat;
    send(1, 8'hFF);
    get(1, w, f, lat);
    checks++;
    if (w !== 16'hDAAA || f !== 1'b0 || lat != 9) begin
      failures++;
      $display("FAIL frame1_word: got enc=%h flush=%b lat=%0d, required DAAA 0 9", w, f, lat);
    end
    get(1, w, f, lat);
    checks++;
    if (w !== 16'h7000 || f !== 1'b1 || lat != 9) begin
      failures++;
      $display("FAIL frame1_flush: got enc=%h flush=%b lat=%0d, required 7000 1 9", w, f, lat);
    end
    @(negedge clk);
    checks++;
    if (ov1 !== 1'b0 || fw1 !== 1'b0 || eo1 !== 16'h7000 || rdy1 !== 1'b1) begin
      failures++;
      $display("FAIL frame1_after: got ov=%b fw=%b enc=%h rdy=%b, required 0 0 7000 1", ov1, fw1, eo1, rdy1);
    end
  endtask
  task automatic test_zeros();
    logic [15:0] w;
    logic f;
    int lat, words;
    do_reset();
    words = 0;
    for (int i = 0; i < 4; i++) begin
      send(0, 8'h00);
      get(0, w, f, lat);
      if (lat < 40) words++;
      checks++;
      if (w !== 16'h0000 || f !== 1'b0) begin
        failures++;
        $display("FAIL zeros_word%0d: got enc=%h flush=%b, required 0000 0", i, w, f);
      end
    end
    get(0, w, f, lat);
    if (lat < 40) words++;
    checks++;
    if (w !== 16'h0000 || f !== 1'b1 || words != 5) begin
      failures++;
      $display("FAIL zeros_flush: got enc=%h flush=%b words=%0d, required 0000 1 5", w, f, words);
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0]  bytes [6] = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h80, 8'h5A};
    int          gaps  [5] = '{10, 10, 10, 19, 10};
    logic [15:0] exp_w [7];
    logic        exp_f [7];
    int          acc   [6];
    int          sent = 0, got = 0, cyc = 0, consec = 0, k = 0;
    logic        prev_ov = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_w[k] = model(bytes[i]);
      exp_f[k] = 1'b0;
      k++;
      if (i == 3) begin
        exp_w[k] = model(8'h00);
        exp_f[k] = 1'b1;
        k++;
      end
    end
    while (got < 7 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (prev_ov && ov4) consec++;
      prev_ov = ov4;
      if (ov4) begin
        checks++;
        if (eo4 !== exp_w[got] || fw4 !== exp_f[got]) begin
          failures++;
          $display("FAIL b2b_word%0d: got enc=%h flush=%b, required %h %b", got, eo4, fw4, exp_w[got], exp_f[got]);
        end
        got++;
      end
      if (rdy4 && sent < 6) begin
        data_in = bytes[sent];
        vld4 = 1'b1;
        acc[sent] = cyc;
        sent++;
      end else begin
        data_in = 8'($urandom);
        if (rdy4) vld4 = 1'b0;
      end
    end
    vld4 = 1'b0;
    checks++;
    if (got != 7 || sent != 6 || consec != 0) begin
      failures++;
      $display("FAIL b2b_count: got words=%0d sent=%0d consecutive=%0d, required 7 6 0", got, sent, consec);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (acc[i+1] - acc[i] != gaps[i]) begin
        failures++;
        $display("FAIL b2b_gap%0d: got %0d cycles, required %0d", i, acc[i+1] - acc[i], gaps[i]);
      end
    end
  endtask
  task automatic test_reset_mid();
    logic [15:0] w;
    logic f;
    int lat, seen;
    do_reset();
    send(0, 8'h80);
    get(0, w, f, lat);
    send(0, 8'hFF);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({rdy4, ov4, fw4, bz4, eo4} !== 20'h0) begin
      failures++;
      $display("FAIL midreset_outputs: got rdy=%b ov=%b fw=%b busy=%b enc=%h, required all 0", rdy4, ov4, fw4, bz4, eo4);
    end
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (ov4) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL midreset_no_word: got %0d out_valid pulses, required 0", seen);
    end
    send(0, 8'h80);
    get(0, w, f, lat);
    checks++;
    if (w !== 16'hEC00 || f !== 1'b0 || lat != 9) begin
      failures++;
      $display("FAIL midreset_next: got enc=%h flush=%b lat=%0d, required EC00 0 9", w, f, lat);
    end
  endtask
  task automatic test_random();
    logic [15:0] w, e;
    logic [7:0]  b;
    logic        f;
    int          lat;
    do_reset();
    for (int fr = 0; fr < 3; fr++) begin
      for (int i = 0; i < 4; i++) begin
        b = 8'($urandom);
        e = model(b);
        send(0, b);
        get(0, w, f, lat);
        checks++;
        if (w !== e || f !== 1'b0 || lat != 9) begin
          failures++;
          $display("FAIL rand_f%0d_b%0d: data=%h got enc=%h flush=%b lat=%0d, required %h 0 9", fr, i, b, w, f, lat, e);
        end
      end
      e = model(8'h00);
      get(0, w, f, lat);
      checks++;
      if (w !== e || f !== 1'b1 || lat != 9) begin
        failures++;
        $display("FAIL rand_flush%0d: got enc=%h flush=%b lat=%0d, required %h 1 9", fr, w, f, lat, e);
      end
    end
  endtask
  initial begin
    mst = 2'b00;
    test_reset();
    test_single();
    test_frame1();
    test_zeros();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
